game_timer: RTL
===============

GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 100_000_000, giving clk cycles per elapsed second.
REQ-002 SHALL have port clk, input, 1, the single system clock.
REQ-003 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, a one-cycle pulse that begins a new game.
REQ-005 SHALL have port pause_tgl, input, 1, a one-cycle pulse that toggles RUN and PAUSE.
REQ-006 SHALL have port game_over, input, 1, a one-cycle pulse (board solved) that freezes the time.
REQ-007 SHALL have port return_req, input, 1, a one-cycle pulse (return button clicked on over screen) that goes back to idle.
REQ-008 SHALL have port enable_time_over, input, 4, the per-digit region enables from the over-screen pixel generator.
REQ-009 SHALL have port digit_m1/digit_m0/digit_s1/digit_s0, output, 4 each, the registered BCD time mm:ss.
REQ-010 SHALL have port time_digit, output, 4, the registered glyph index for the digit-ROM select.
REQ-011 SHALL have port state, output, 2, the current FSM state.
REQ-012 SHALL have port sec_tick, output, 1, a one-cycle pulse on each counted second.
REQ-013 SHALL have port saturated, output, 1, high once the time is held at 99:59.

Function
REQ-014 SHALL implement FSM states IDLE=0, RUN=1, PAUSE=2, OVER=3.
REQ-015 SHALL go IDLE->RUN on start, clearing the digits, the divider and saturated in the same edge.
REQ-016 SHALL go RUN->PAUSE and PAUSE->RUN on pause_tgl.
REQ-017 SHALL go RUN or PAUSE -> OVER on game_over, with game_over taking priority over a simultaneous pause_tgl.
REQ-018 SHALL go OVER->RUN on start (digits cleared) and OVER->IDLE on return_req (digits cleared), with start taking priority if both are asserted.
REQ-019 SHALL ignore start in RUN/PAUSE, pause_tgl in IDLE/OVER, and return_req outside OVER.
REQ-020 SHALL count the divider 0..TICK_CYCLES-1 only in RUN, wrap it to 0, and hold its value in PAUSE.
REQ-021 SHALL assert sec_tick for exactly the cycle after the divider reaches TICK_CYCLES-1, with the digits updated on that same edge.
REQ-022 SHALL not count a terminal-count cycle toward a tick if it coincides with pause_tgl or game_over; the state change wins.
REQ-023 SHALL increment the BCD time per tick: s0 0..9 carries into s1 0..5, which carries into m0 0..9, which carries into m1 0..9.
REQ-024 SHALL, on a tick at 99:59, leave the digits unchanged, set saturated, and keep sec_tick pulsing.
REQ-025 SHALL never produce a BCD digit above 9, nor s1 above 5.
REQ-026 SHALL register time_digit one cycle after enable_time_over, matching the digit-ROM latency.
REQ-027 SHALL select time_digit as m1 for enable_time_over[3], m0 for [2], s1 for [1], s0 for [0], and 4'hF for none.
REQ-028 SHALL resolve multiple enable_time_over bits by priority, highest index first.
REQ-029 SHALL hold the digits frozen in OVER and PAUSE.

Reset
REQ-030 SHALL, on rst sampled high, set state=IDLE, all digits=0, divider=0, sec_tick=0, saturated=0 and time_digit=4'hF.
REQ-031 SHALL give rst priority over every other input, including a reset asserted mid-count or mid-tick.

Structure
REQ-032 SHALL place the state encodings, the BCD limits (9, 5) and the blank glyph 4'hF in a shared package used by the over-screen pixel generator.
REQ-033 SHALL use a single sub-module, sec_divider, providing the run-gated, clearable divider and the tick pulse.

Verification
REQ-034 SHALL cover, with TICK_CYCLES=4: rst, start, then 40 cycles in RUN -> 10 sec_tick pulses, digits 00:10.
REQ-035 SHALL cover divider hold: pause_tgl at divider=2, wait 20 cycles, pause_tgl -> no tick while paused, next tick 2 cycles after resume.
REQ-036 SHALL cover carry/saturation: preload-free run to 09:59 then one tick -> 10:00; run to 99:59 then one tick -> 99:59 with saturated=1.
REQ-037 SHALL cover game_over and pause_tgl in the same cycle -> state=OVER and digits frozen for 100 cycles.
REQ-038 SHALL cover time_digit at 12:34: enable_time_over=1000,0100,0010,0001,0000 -> time_digit 1,2,3,4,F, each one cycle later, and 0110 -> 2.
REQ-039 SHALL cover reset in OVER, with return_req and start together -> RUN with 00:00; rst mid-RUN -> IDLE with 00:00 on the next edge.

Source files
------------

// File: rtl/game_timer_pkg.sv
// Shared definitions for the game timer and the over-screen pixel generator:
// FSM state encodings, BCD digit limits, the blank glyph index and the
// digit-select helper that maps region enables onto a glyph.
package game_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX      = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] BLANK_GLYPH  = 4'hF;

    // Highest-index enable wins; digits packed as {m1, m0, s1, s0}.
    function automatic logic [3:0] select_glyph(input logic [3:0]  en,
                                                input logic [15:0] digits);
        logic [3:0] glyph;
        glyph = BLANK_GLYPH;
        if (en[3])
            glyph = digits[15:12];
        else if (en[2])
            glyph = digits[11:8];
        else if (en[1])
            glyph = digits[7:4];
        else if (en[0])
            glyph = digits[3:0];
        return glyph;
    endfunction

endpackage

// File: rtl/game_timer_sec_divider.sv
// Run-gated, clearable clock divider producing one tick per elapsed second.
// 'wrap' flags the terminal-count cycle combinationally so the owner can
// update its digits on the same edge that raises the registered 'tick'.
module sec_divider #(
    parameter int TICK_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic wrap,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] count;

    assign wrap = enable && !clear && (count == LAST);

    // Count only while enabled, hold otherwise; tick follows the wrap cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (clear) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= wrap;
            if (enable)
                count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/game_timer.sv
// Game timer: IDLE/RUN/PAUSE/OVER control FSM, mm:ss BCD elapsed time that
// saturates at 99:59, and a registered glyph select for the over screen.
module game_timer
    import game_timer_pkg::*;
#(
    parameter int TICK_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause_tgl,
    input  logic       game_over,
    input  logic       return_req,
    input  logic [3:0] enable_time_over,
    output logic [3:0] digit_m1,
    output logic [3:0] digit_m0,
    output logic [3:0] digit_s1,
    output logic [3:0] digit_s0,
    output logic [3:0] time_digit,
    output logic [1:0] state,
    output logic       sec_tick,
    output logic       saturated
);

    state_t cur_state;
    logic   div_clear;
    logic   div_enable;
    logic   wrap;
    logic   at_max;

    assign state = cur_state;

    // A pause or game-over in the terminal cycle blocks the count so the
    // state change wins and no second is credited.
    assign div_enable = (cur_state == RUN) && !pause_tgl && !game_over;
    assign div_clear  = start && ((cur_state == IDLE) || (cur_state == OVER));
    assign at_max     = (digit_m1 == BCD_MAX) && (digit_m0 == BCD_MAX) &&
                        (digit_s1 == SEC_TENS_MAX) && (digit_s0 == BCD_MAX);

    sec_divider #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .clear (div_clear),
        .enable(div_enable),
        .wrap  (wrap),
        .tick  (sec_tick)
    );

    // Control FSM together with the BCD time and saturation flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= IDLE;
            digit_m1  <= 4'd0;
            digit_m0  <= 4'd0;
            digit_s1  <= 4'd0;
            digit_s0  <= 4'd0;
            saturated <= 1'b0;
        end else begin
            case (cur_state)
                IDLE: begin
                    if (start) begin
                        cur_state <= RUN;
                        digit_m1  <= 4'd0;
                        digit_m0  <= 4'd0;
                        digit_s1  <= 4'd0;
                        digit_s0  <= 4'd0;
                        saturated <= 1'b0;
                    end
                end
                RUN: begin
                    if (game_over) begin
                        cur_state <= OVER;
                    end else if (pause_tgl) begin
                        cur_state <= PAUSE;
                    end else if (wrap) begin
                        if (at_max) begin
                            saturated <= 1'b1;
                        end else if (digit_s0 != BCD_MAX) begin
                            digit_s0 <= digit_s0 + 4'd1;
                        end else begin
                            digit_s0 <= 4'd0;
                            if (digit_s1 != SEC_TENS_MAX) begin
                                digit_s1 <= digit_s1 + 4'd1;
                            end else begin
                                digit_s1 <= 4'd0;
                                if (digit_m0 != BCD_MAX) begin
                                    digit_m0 <= digit_m0 + 4'd1;
                                end else begin
                                    digit_m0 <= 4'd0;
                                    digit_m1 <= digit_m1 + 4'd1;
                                end
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (game_over)
                        cur_state <= OVER;
                    else if (pause_tgl)
                        cur_state <= RUN;
                end
                OVER: begin
                    if (start || return_req) begin
                        cur_state <= start ? RUN : IDLE;
                        digit_m1  <= 4'd0;
                        digit_m0  <= 4'd0;
                        digit_s1  <= 4'd0;
                        digit_s0  <= 4'd0;
                        saturated <= 1'b0;
                    end
                end
                default: cur_state <= IDLE;
            endcase
        end
    end

    // Glyph select registered to line up with the digit-ROM latency.
    always_ff @(posedge clk) begin
        if (rst)
            time_digit <= BLANK_GLYPH;
        else
            time_digit <= select_glyph(enable_time_over,
                                       {digit_m1, digit_m0, digit_s1, digit_s0});
    end

endmodule
